// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control unit and the shared datapath.
// master: the control unit. It reads opcode/funct/zero/mem_ready and drives all selects
//         and strobes plus the debug state.
// slave:  the datapath/memory side, which sees the opposite directions.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ext_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op,
           illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core. It steps the shared datapath through
// fetch/decode/execute/memory/writeback and drives every datapath select.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high. It also gates all strobes low combinationally.
//   bus   - control bus (master side). Inputs: opcode, funct, zero, mem_ready.
//           Outputs: PC/memory/register-file strobes, mux selects, alu_op, ext_op,
//           illegal and the debug state.
module multicycle_control (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_if.master       bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StImmExe = 4'd9,
    StJump   = 4'd10
  } state_e;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpAndi = 6'h0C;
  localparam logic [5:0] OpOri  = 6'h0D;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;

  state_e state_q, state_d;

  // Un-gated strobes. reset masks them further down.
  logic       pc_write_c, pc_write_cond_c, ir_write_c, mem_read_c, mem_write_c;
  logic       reg_write_c, illegal_c;

  // funct is decoded by the ALU control and zero is used by the PC logic. This block
  // does not read either of them.
  logic unused_inputs;
  assign unused_inputs = ^{bus.funct, bus.zero};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = StFetch;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    ir_write_c      = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    illegal_c       = 1'b0;
    bus.pc_src      = 2'b00;
    bus.iord        = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_op      = AluAdd;
    bus.ext_op      = 1'b1;

    case (state_q)
      StFetch: begin
        mem_read_c    = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end else begin
          state_d    = StFetch;
        end
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OpLw, OpSw:              state_d = StMemAdr;
          OpR:                     state_d = StExecR;
          OpBeq:                   state_d = StBranch;
          OpAddi, OpAndi, OpOri:   state_d = StImmExe;
          OpJ:                     state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_c = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read_c = 1'b1;
        bus.iord   = 1'b1;
        state_d    = bus.mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write_c    = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = StFetch;
      end
      StMemWr: begin
        mem_write_c = 1'b1;
        bus.iord    = 1'b1;
        state_d     = bus.mem_ready ? StFetch : StMemWr;
      end
      StExecR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = AluFunct;
        state_d       = StAluWb;
      end
      StAluWb: begin
        reg_write_c = 1'b1;
        bus.reg_dst = (bus.opcode == OpR);
        state_d     = StFetch;
      end
      StBranch: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_op      = AluSub;
        pc_write_cond_c = 1'b1;
        bus.pc_src      = 2'b01;
        state_d         = StFetch;
      end
      StImmExe: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        case (bus.opcode)
          OpAndi: begin
            bus.alu_op = AluAnd;
            bus.ext_op = 1'b0;
          end
          OpOri: begin
            bus.alu_op = AluOr;
            bus.ext_op = 1'b0;
          end
          default: begin
            bus.alu_op = AluAdd;
            bus.ext_op = 1'b1;
          end
        endcase
        state_d = StAluWb;
      end
      StJump: begin
        pc_write_c = 1'b1;
        bus.pc_src = 2'b10;
        state_d    = StFetch;
      end
      // Encodings 11-15: recover to FETCH with all strobes low.
      default: state_d = StFetch;
    endcase
  end

  // Reset kills every strobe at once, so an aborted instruction issues no write.
  assign bus.pc_write      = pc_write_c      & ~reset;
  assign bus.pc_write_cond = pc_write_cond_c & ~reset;
  assign bus.ir_write      = ir_write_c      & ~reset;
  assign bus.mem_read      = mem_read_c      & ~reset;
  assign bus.mem_write     = mem_write_c     & ~reset;
  assign bus.reg_write     = reg_write_c     & ~reset;
  assign bus.illegal       = illegal_c       & ~reset;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. A reference model expands each instruction into its
// expected state path, including wait states. A per-state control-word table is applied
// every cycle, and per-instruction write/illegal counts are checked.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       illegal;
  } ctrl_t;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rw_cnt, mw_cnt, ill_cnt;
  ctrl_t tab [0:10];
  int    st_q[$];
  bit    rdy_q[$];

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D};
  endfunction

  function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] op, input bit rdy,
                                     input bit rst);
    ctrl_t c;
    c = tab[s];
    if (s == 0) begin
      c.ir_write = rdy;
      c.pc_write = rdy;
    end
    if (s == 1) c.illegal = !is_legal(op);
    if (s == 7) c.reg_dst = (op == 6'h00);
    if (s == 9 && op == 6'h0C) begin c.alu_op = 3'b011; c.ext_op = 1'b0; end
    if (s == 9 && op == 6'h0D) begin c.alu_op = 3'b100; c.ext_op = 1'b0; end
    if (rst) begin
      c.pc_write = 0; c.pc_write_cond = 0; c.ir_write = 0; c.mem_read = 0;
      c.mem_write = 0; c.reg_write = 0; c.illegal = 0;
    end
    return c;
  endfunction

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle. Inputs are driven just after negedge and outputs are checked 1ns
  // later, well away from the posedge.
  task automatic step(input string tag, input logic [5:0] op, input bit rdy, input bit rst,
                      input int exp_st);
    logic [5:0] drv_op;
    ctrl_t      got, exp;
    drv_op        = (exp_st == 0) ? 6'($urandom) : op;
    reset         = rst;
    bus.opcode    = drv_op;
    bus.funct     = 6'($urandom);
    bus.zero      = 1'($urandom);
    bus.mem_ready = rdy;
    #1;
    exp = exp_ctrl(exp_st, drv_op, rdy, rst);
    got = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.iord, bus.mem_read,
           bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
           bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.ext_op, bus.illegal};
    checks++;
    assert (bus.state === 4'(exp_st)) else begin
      failures++;
      $error("FAIL %s state got=%0d exp=%0d", tag, bus.state, exp_st);
    end
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s ctrl st=%0d op=%h got=%05h exp=%05h", tag, exp_st, drv_op, got, exp);
    end
    rw_cnt  += int'(got.reg_write);
    mw_cnt  += int'(got.mem_write);
    ill_cnt += int'(got.illegal);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference path: states visited by one instruction, with mem_ready per cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input int nf,
                           input int nm);
    int exp_rw, exp_mw, exp_ill;
    st_q.delete();
    rdy_q.delete();
    for (int i = 0; i < nf; i++) begin st_q.push_back(0); rdy_q.push_back(0); end
    st_q.push_back(0); rdy_q.push_back(1);
    st_q.push_back(1); rdy_q.push_back(1'($urandom));
    exp_rw = 0; exp_mw = 0; exp_ill = 0;
    case (op)
      6'h23: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < nm; i++) begin st_q.push_back(3); rdy_q.push_back(0); end
        st_q.push_back(3); rdy_q.push_back(1);
        st_q.push_back(4); rdy_q.push_back(1'($urandom));
        exp_rw = 1;
      end
      6'h2B: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < nm; i++) begin st_q.push_back(5); rdy_q.push_back(0); end
        st_q.push_back(5); rdy_q.push_back(1);
        exp_mw = nm + 1;
      end
      6'h00: begin
        st_q.push_back(6); rdy_q.push_back(1'($urandom));
        st_q.push_back(7); rdy_q.push_back(1'($urandom));
        exp_rw = 1;
      end
      6'h08, 6'h0C, 6'h0D: begin
        st_q.push_back(9); rdy_q.push_back(1'($urandom));
        st_q.push_back(7); rdy_q.push_back(1'($urandom));
        exp_rw = 1;
      end
      6'h04: begin st_q.push_back(8); rdy_q.push_back(1'($urandom)); end
      6'h02: begin st_q.push_back(10); rdy_q.push_back(1'($urandom)); end
      default: exp_ill = 1;
    endcase
    rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
    foreach (st_q[i]) step(tag, op, rdy_q[i], 1'b0, st_q[i]);
    check_int({tag, "_reg_write_cnt"}, rw_cnt, exp_rw);
    check_int({tag, "_mem_write_cnt"}, mw_cnt, exp_mw);
    check_int({tag, "_illegal_cnt"}, ill_cnt, exp_ill);
  endtask

  initial begin
    ctrl_t c, t;
    logic [5:0] ops [0:7];
    logic [5:0] op;
    int k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D};
    c = '0; c.ext_op = 1'b1;
    t = c; t.mem_read = 1; t.alu_src_b = 2'b01;                       tab[0]  = t;
    t = c; t.alu_src_b = 2'b11;                                       tab[1]  = t;
    t = c; t.alu_src_a = 1; t.alu_src_b = 2'b10;                      tab[2]  = t;
    t = c; t.mem_read = 1; t.iord = 1;                                tab[3]  = t;
    t = c; t.reg_write = 1; t.mem_to_reg = 1;                         tab[4]  = t;
    t = c; t.mem_write = 1; t.iord = 1;                               tab[5]  = t;
    t = c; t.alu_src_a = 1; t.alu_op = 3'b010;                        tab[6]  = t;
    t = c; t.reg_write = 1;                                           tab[7]  = t;
    t = c; t.alu_src_a = 1; t.alu_op = 3'b001; t.pc_write_cond = 1;
           t.pc_src = 2'b01;                                          tab[8]  = t;
    t = c; t.alu_src_a = 1; t.alu_src_b = 2'b10;                      tab[9]  = t;
    t = c; t.pc_write = 1; t.pc_src = 2'b10;                          tab[10] = t;

    reset = 1'b1; bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step("reset_hold", 6'h00, 1'b1, 1'b1, 0);

    // Reset mid-lw: abort in MEMRD, no reg_write, strobes low while reset is high.
    rw_cnt = 0;
    step("rst_lw", 6'h23, 1'b1, 1'b0, 0);
    step("rst_lw", 6'h23, 1'b1, 1'b0, 1);
    step("rst_lw", 6'h23, 1'b1, 1'b0, 2);
    step("rst_lw_memrd", 6'h23, 1'b1, 1'b1, 3);
    check_int("rst_lw_no_reg_write", rw_cnt, 0);

    run_instr("lw_wait", 6'h23, 0, 2);
    run_instr("addi", 6'h08, 0, 0);
    run_instr("andi", 6'h0C, 0, 0);
    run_instr("ori", 6'h0D, 0, 0);
    run_instr("beq", 6'h04, 0, 0);
    run_instr("j", 6'h02, 0, 0);
    run_instr("illegal", 6'h3F, 0, 0);
    run_instr("sw_fwait", 6'h2B, 3, 0);
    run_instr("r_type", 6'h00, 1, 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 8);
      if (k == 8) op = 6'($urandom_range(16, 31));
      else        op = ops[k];
      run_instr("rand", op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    step("final_fetch", 6'h00, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle core. It sequences the shared datapath through fetch, decode, execute, memory and writeback states, and drives every datapath select. This includes `ext_op`, which chooses sign or zero extension of the 16-bit immediate in the extender. It sits beside the register file, ALU and extender, decodes the opcode/funct held in the instruction register, and handshakes with the unified instruction/data memory via `mem_ready`.

## Interface
- No parameters; all encodings are fixed.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from DECODE onward.
- `funct` in 6: IR[5:0]; passed through only as the ALU-decode qualifier.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if `zero`.
- `pc_src` out 2: next-PC select. 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: destination select. 1 = rd, 0 = rt.
- `mem_to_reg` out 1: writeback data select. 1 = MDR, 0 = ALUOut.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = reg A.
- `alu_src_b` out 2: ALU B select. 00 = reg B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `alu_op` out 3: 000 add, 001 sub, 010 use funct, 011 and, 100 or.
- `ext_op` out 1: 1 = sign-extend immediate, 0 = zero-extend.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state encoding, for debug.

## Operation

**Opcodes:** R 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, andi 0x0C, ori 0x0D.

**Default outputs.** Any strobe not listed for a state is 0. Every select not listed for a state is 0, except `ext_op`, which defaults to 1.

**States** (encoding in brackets):
- **FETCH [0]**
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add.
  - If `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE [1]**
  - Drives `alu_src_a`=0, `alu_src_b`=11, add, `ext_op`=1. This precomputes the branch target.
  - Next state by opcode:
    - lw/sw → MEMADR.
    - R → EXEC_R.
    - beq → BRANCH.
    - addi/andi/ori → IMMEXE.
    - j → JUMP.
    - Anything else → FETCH, with `illegal`=1 this cycle.
- **MEMADR [2]**
  - Drives `alu_src_a`=1, `alu_src_b`=10, add, `ext_op`=1.
  - lw → MEMRD; sw → MEMWR.
- **MEMRD [3]**
  - Drives `mem_read`=1, `iord`=1.
  - On `mem_ready` go to MEMWB, otherwise hold.
- **MEMWB [4]**
  - Drives `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1.
  - Go to FETCH.
- **MEMWR [5]**
  - Drives `mem_write`=1, `iord`=1.
  - On `mem_ready` go to FETCH, otherwise hold.
- **EXEC_R [6]**
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010.
  - Go to ALUWB.
- **ALUWB [7]**
  - Drives `reg_write`=1, `mem_to_reg`=0. `reg_dst`=1 if opcode is R, else 0.
  - Go to FETCH.
- **BRANCH [8]**
  - Drives `alu_src_a`=1, `alu_src_b`=00, sub, `pc_write_cond`=1, `pc_src`=01.
  - Go to FETCH.
- **IMMEXE [9]**
  - Drives `alu_src_a`=1, `alu_src_b`=10.
  - addi: add, `ext_op`=1. andi: and, `ext_op`=0. ori: or, `ext_op`=0.
  - Go to ALUWB.
- **JUMP [10]**
  - Drives `pc_write`=1, `pc_src`=10.
  - Go to FETCH.
- **Encodings 11–15** are unreachable. If entered, the block goes to FETCH next cycle with all strobes 0.

**Output style.** Outputs are a combinational decode of `state`, `opcode` and `mem_ready`. Only `ir_write`/`pc_write` in FETCH and the exits of the memory states depend on `mem_ready`.

## Timing
- **Reset.** When `reset` is high at a clock edge, `state` becomes FETCH (0) on that edge. While `reset` is high, all strobes are forced to 0 combinationally: `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `illegal`.
- **First fetch.** The first cycle after reset deasserts is FETCH with `mem_read`=1.
- **Reset mid-instruction.** The instruction is aborted and no pending `reg_write` or `mem_write` is issued.
- **Latency with `mem_ready` held high:** lw 5 cycles; sw, R, addi/andi/ori 4 cycles; beq and j 3 cycles; illegal opcode 2 cycles.
- **Wait states.** Each low-`mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes hold steady during the wait.
- **Memory strobe rule.** `mem_read` and `mem_write` are never high in the same cycle.
- **Single-cycle writes.** `reg_write` is high for exactly one cycle per writing instruction.

## Test plan
1. **Reset mid-lw.** Hold `mem_ready`=1, run lw, and assert `reset` in MEMRD. Required: `state`=0 next cycle, no `reg_write` pulse, and `mem_read`=0 during reset.
2. **lw with wait states.** Hold `mem_ready`=1 except 2 low cycles in MEMRD. Required: the state sequence 0,1,2,3,3,3,4,0 and exactly one `reg_write` with `mem_to_reg`=1, `reg_dst`=0.
3. **Extension select in IMMEXE.** Run addi, andi and ori back-to-back. Required in IMMEXE: `ext_op`=1/0/0 and `alu_op`=000/011/100. Required in ALUWB: `reg_dst`=0.
4. **beq.** Run beq with `zero`=1. Required in the third cycle: `pc_write_cond`=1, `pc_src`=01, `alu_op`=001, then FETCH. Run j. Required: `pc_write`=1 with `pc_src`=10 in state 10.
5. **Illegal opcode.** Opcode 0x3F. Required: `illegal`=1 for exactly one cycle in DECODE, return to FETCH, and no `reg_write` or `mem_write`.
6. **sw with FETCH wait.** Run sw with `mem_ready`=0 for 3 cycles in FETCH. Required: `ir_write`/`pc_write` stay 0 until the `mem_ready` cycle, `mem_write`=1 with `iord`=1 in MEMWR, and 7 cycles total.
